// File: rtl/multicycle_core_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer of the 9-bit accumulator
// core. It holds the sequencer state type, the opcode constants that the
// sequencer decodes, and the PC update selector used by seq_pc_next.
package multicycle_core_seq_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  // Opcode field is ir[IW-1:IW-4]; every other opcode is treated as an ALU op.
  localparam logic [3:0] kLDS = 4'hC;  // load (T=0) / store (T=1)
  localparam logic [3:0] kBRC = 4'hD;  // conditional relative branch on ALU ZERO
  localparam logic [3:0] kHLT = 4'hF;  // stop the core

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_FWD  = 2'd2,
    PC_BWD  = 2'd3
  } pc_op_t;

endpackage

// File: rtl/multicycle_core_seq_pc_next.sv
// seq_pc_next: combinational next-PC selection for the sequencer.
// Ports:
//   pc      in  PCW    current program counter
//   op      in  2      hold / +1 / +offset / -offset
//   offset  in  PCW-1  branch magnitude (unsigned)
//   pc_next out PCW    updated PC; all arithmetic wraps modulo 2**PCW
module seq_pc_next
  import multicycle_core_seq_pkg::*;
#(
  parameter int PCW = 10
) (
  input  logic [PCW-1:0] pc,
  input  pc_op_t         op,
  input  logic [PCW-2:0] offset,
  output logic [PCW-1:0] pc_next
);

  logic [PCW-1:0] off_ext;
  logic [PCW-1:0] one;

  assign off_ext = {1'b0, offset};
  assign one     = {{(PCW-1){1'b0}}, 1'b1};

  // Plain PCW-bit add/subtract gives the modulo wrap in both directions.
  always_comb begin
    case (op)
      PC_INC:  pc_next = pc + one;
      PC_FWD:  pc_next = pc + off_ext;
      PC_BWD:  pc_next = pc - off_ext;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/multicycle_core_seq.sv
// multicycle_core_seq: multi-cycle sequencer for the 9-bit accumulator core.
// Owns PC, instruction register, cycle/retire counters and halt; steps each
// instruction through FETCH/EXEC/MEM/WB so data memory may take a variable
// number of cycles behind a req/ack handshake.
// Ports:
//   CLK        in   clock, rising edge
//   start      in   asynchronous active-high reset
//   instr      in   InstROM word at address pc
//   alu_zero   in   ALU ZERO flag, sampled in EXEC
//   alu_halt   in   ALU halt request, sampled in EXEC
//   b_sign     in   branch direction, 1 = backward
//   b_offset   in   branch magnitude
//   mem_ack    in   data_mem completion pulse
//   pc         out  program counter
//   ir         out  latched instruction
//   rf_we      out  reg_file write strobe (WB only)
//   wb_sel_mem out  write-back source, 1 = data_mem
//   mem_req    out  data_mem request level
//   mem_we     out  1 = store, 0 = load, valid with mem_req
//   mem_err    out  sticky memory timeout flag
//   halt       out  sticky halt flag
//   cycle_ct   out  saturating count of non-halted cycles
//   instr_ct   out  saturating count of retired instructions
//   dbg_state  out  current sequencer state
// Handshake: mem_req is a level held for every MEM cycle; a transfer
// completes on the first cycle in MEM where mem_ack is high. mem_ack seen in
// any other state has no effect. A timeout ends the request without a transfer.
module multicycle_core_seq
  import multicycle_core_seq_pkg::*;
#(
  parameter int IW          = 9,
  parameter int PCW         = 10,
  parameter int CTW         = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic           CLK,
  input  logic           start,
  input  logic [IW-1:0]  instr,
  input  logic           alu_zero,
  input  logic           alu_halt,
  input  logic           b_sign,
  input  logic [PCW-2:0] b_offset,
  input  logic           mem_ack,
  output logic [PCW-1:0] pc,
  output logic [IW-1:0]  ir,
  output logic           rf_we,
  output logic           wb_sel_mem,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_err,
  output logic           halt,
  output logic [CTW-1:0] cycle_ct,
  output logic [CTW-1:0] instr_ct,
  output seq_state_t     dbg_state
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  seq_state_t     state, state_next;
  pc_op_t         pc_op;
  logic [PCW-1:0] pc_upd;
  logic [TW-1:0]  wait_ct;
  logic [3:0]     opcode;
  logic           is_store;
  logic           retire;
  logic           timeout;
  logic           halt_set;
  logic [CTW-1:0] ct_one;

  assign opcode    = ir[IW-1:IW-4];
  assign is_store  = ir[0];
  assign dbg_state = state;
  assign ct_one    = {{(CTW-1){1'b0}}, 1'b1};

  seq_pc_next #(.PCW(PCW)) u_pc_next (
    .pc      (pc),
    .op      (pc_op),
    .offset  (b_offset),
    .pc_next (pc_upd)
  );

  always_comb begin
    state_next = state;
    pc_op      = PC_HOLD;
    retire     = 1'b0;
    timeout    = 1'b0;
    halt_set   = 1'b0;
    rf_we      = 1'b0;
    wb_sel_mem = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      FETCH: state_next = EXEC;
      EXEC: begin
        if (opcode == kHLT || alu_halt) begin
          halt_set   = 1'b1;
          state_next = HALT;
        end else if (opcode == kBRC) begin
          pc_op      = alu_zero ? (b_sign ? PC_BWD : PC_FWD) : PC_INC;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (opcode == kLDS) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        // An ack on the final allowed cycle still counts as a completed transfer.
        if (mem_ack) begin
          if (is_store) begin
            pc_op      = PC_INC;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if ((MEM_TIMEOUT > 0) && (wait_ct == TW'(MEM_TIMEOUT - 1))) begin
          timeout    = 1'b1;
          pc_op      = PC_INC;
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        wb_sel_mem = (opcode == kLDS) && !is_store;
        pc_op      = PC_INC;
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      wait_ct  <= '0;
      mem_err  <= 1'b0;
      halt     <= 1'b0;
      cycle_ct <= '0;
      instr_ct <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_upd;
      if (state == FETCH) ir <= instr;
      if (state == MEM) wait_ct <= wait_ct + TW'(1);
      else              wait_ct <= '0;
      if (timeout)  mem_err <= 1'b1;
      if (halt_set) halt    <= 1'b1;
      // Both counters stop at all-ones instead of wrapping.
      if (!halt && (cycle_ct != '1)) cycle_ct <= cycle_ct + ct_one;
      if (retire && (instr_ct != '1)) instr_ct <= instr_ct + ct_one;
    end
  end

endmodule

// File: tb/tb_multicycle_core_seq.sv
// Bench for multicycle_core_seq. Two instances run the same program from a
// shared ROM: dut_a (wait forever on memory, 16-bit counters) and dut_b
// (4-cycle memory timeout, 6-bit counters). Side inputs (ALU flags, branch
// fields, memory latency) are tables indexed by each instance's own PC.
module tb_multicycle_core_seq;
  import multicycle_core_seq_pkg::*;

  localparam int NPC = 1024;
  localparam int P_F = 0, P_E = 1, P_M = 2, P_W = 3, P_H = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic start;

  // ---------------- program and side-input tables ----------------
  logic [8:0] rom [NPC];
  bit         zt  [NPC];
  bit         st  [NPC];
  bit         ht  [NPC];
  logic [8:0] ot  [NPC];
  int         dt  [NPC];  // memory latency in cycles, 0 = never acks
  bit         spur_en;
  logic       spur;

  // ---------------- dut_a ----------------
  logic [8:0]  instr_a, b_offset_a, ir_a;
  logic        alu_zero_a, alu_halt_a, b_sign_a, ack_a;
  logic [9:0]  pc_a;
  logic        rf_we_a, wb_sel_a, mem_req_a, mem_we_a, mem_err_a, halt_a;
  logic [15:0] cyc_a, ins_a;
  seq_state_t  st_a;
  int          rc_a;

  // ---------------- dut_b ----------------
  logic [8:0]  instr_b, b_offset_b, ir_b;
  logic        alu_zero_b, alu_halt_b, b_sign_b, ack_b;
  logic [9:0]  pc_b;
  logic        rf_we_b, wb_sel_b, mem_req_b, mem_we_b, mem_err_b, halt_b;
  logic [5:0]  cyc_b, ins_b;
  seq_state_t  st_b;
  int          rc_b;

  assign instr_a    = rom[pc_a];
  assign alu_zero_a = zt[pc_a];
  assign alu_halt_a = ht[pc_a];
  assign b_sign_a   = st[pc_a];
  assign b_offset_a = ot[pc_a];
  assign ack_a      = mem_req_a ? (dt[pc_a] != 0 && rc_a == dt[pc_a] - 1) : spur;

  assign instr_b    = rom[pc_b];
  assign alu_zero_b = zt[pc_b];
  assign alu_halt_b = ht[pc_b];
  assign b_sign_b   = st[pc_b];
  assign b_offset_b = ot[pc_b];
  assign ack_b      = mem_req_b ? (dt[pc_b] != 0 && rc_b == dt[pc_b] - 1) : spur;

  // Memory responder: counts request cycles; random acks while idle.
  always @(posedge clk) begin
    rc_a <= mem_req_a ? rc_a + 1 : 0;
    rc_b <= mem_req_b ? rc_b + 1 : 0;
    spur <= spur_en && ($urandom_range(0, 3) == 0);
  end

  multicycle_core_seq #(.IW(9), .PCW(10), .CTW(16), .MEM_TIMEOUT(0)) dut_a (
    .CLK(clk), .start(start), .instr(instr_a), .alu_zero(alu_zero_a),
    .alu_halt(alu_halt_a), .b_sign(b_sign_a), .b_offset(b_offset_a),
    .mem_ack(ack_a), .pc(pc_a), .ir(ir_a), .rf_we(rf_we_a),
    .wb_sel_mem(wb_sel_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_err(mem_err_a), .halt(halt_a), .cycle_ct(cyc_a), .instr_ct(ins_a),
    .dbg_state(st_a)
  );

  multicycle_core_seq #(.IW(9), .PCW(10), .CTW(6), .MEM_TIMEOUT(4)) dut_b (
    .CLK(clk), .start(start), .instr(instr_b), .alu_zero(alu_zero_b),
    .alu_halt(alu_halt_b), .b_sign(b_sign_b), .b_offset(b_offset_b),
    .mem_ack(ack_b), .pc(pc_b), .ir(ir_b), .rf_we(rf_we_b),
    .wb_sel_mem(wb_sel_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_err(mem_err_b), .halt(halt_b), .cycle_ct(cyc_b), .instr_ct(ins_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase per instruction: fetch, execute, memory wait, write-back, halted.
  typedef struct {
    int ph; int pc; int ir; int wt; bit halt; bit err; int cyc; int ins;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int tmo, int ctmax);
    mdl_t n;
    int   op, t;
    bit   ret;
    n   = m;
    op  = (m.ir >> 5) & 15;
    t   = m.ir & 1;
    ret = 0;
    if (!m.halt && m.cyc < ctmax) n.cyc = m.cyc + 1;
    case (m.ph)
      P_F: begin n.ir = int'(rom[m.pc]); n.ph = P_E; end
      P_E: begin
        if (op == int'(kHLT) || ht[m.pc]) begin
          n.halt = 1; n.ph = P_H;
        end else if (op == int'(kBRC)) begin
          if (!zt[m.pc])     n.pc = (m.pc + 1) % NPC;
          else if (st[m.pc]) n.pc = (m.pc - int'(ot[m.pc]) + NPC) % NPC;
          else               n.pc = (m.pc + int'(ot[m.pc])) % NPC;
          ret = 1; n.ph = P_F;
        end else if (op == int'(kLDS)) begin
          n.ph = P_M; n.wt = 0;
        end else begin
          n.ph = P_W;
        end
      end
      P_M: begin
        if (dt[m.pc] > 0 && m.wt == dt[m.pc] - 1) begin
          if (t == 1) begin n.pc = (m.pc + 1) % NPC; ret = 1; n.ph = P_F; end
          else n.ph = P_W;
        end else if (tmo > 0 && m.wt == tmo - 1) begin
          n.err = 1; n.pc = (m.pc + 1) % NPC; ret = 1; n.ph = P_F;
        end else begin
          n.wt = m.wt + 1;
        end
      end
      P_W: begin n.pc = (m.pc + 1) % NPC; ret = 1; n.ph = P_F; end
      default: ;
    endcase
    if (ret && m.ins < ctmax) n.ins = m.ins + 1;
    return n;
  endfunction

  always @(posedge clk or posedge start) begin
    if (start) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, 0, 65535);
      mb = step(mb, 4, 63);
    end
  end

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [31:0] pc,
                         input logic [31:0] ir, input logic [31:0] cyc,
                         input logic [31:0] ins, input logic [5:0] fl);
    logic [5:0] ef;
    bit         ld;
    ld = (((m.ir >> 5) & 15) == int'(kLDS)) && ((m.ir & 1) == 0);
    ef = {m.ph == P_W, m.ph == P_W && ld, m.ph == P_M,
          m.ph == P_M && (m.ir & 1) == 1, m.err, m.halt};
    chk({tag, ".pc"}, pc, m.pc);
    chk({tag, ".ir"}, ir, m.ir);
    chk({tag, ".cycle_ct"}, cyc, m.cyc);
    chk({tag, ".instr_ct"}, ins, m.ins);
    chk({tag, ".strobes"}, {26'd0, fl}, {26'd0, ef});
  endtask

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("a", ma, pc_a, ir_a, cyc_a, ins_a,
              {rf_we_a, wb_sel_a, mem_req_a, mem_we_a, mem_err_a, halt_a});
      cmp_dut("b", mb, pc_b, ir_b, cyc_b, ins_b,
              {rf_we_b, wb_sel_b, mem_req_b, mem_we_b, mem_err_b, halt_b});
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8:0] mk(input logic [3:0] op, input logic t);
    return {op, 4'b0000, t};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < NPC; i++) begin
      rom[i] = 9'd0; zt[i] = 0; st[i] = 0; ht[i] = 0; ot[i] = 9'd0; dt[i] = 0;
    end
  endtask

  task automatic brc(input int a, input bit z, input bit s, input int off);
    rom[a] = mk(kBRC, 1'b0); zt[a] = z; st[a] = s; ot[a] = off[8:0];
  endtask

  task automatic load_prog(input int p);
    clear_prog();
    case (p)
      1: begin
        brc(0, 1, 0, 5);
        rom[5] = mk(4'h0, 1'b0);
        brc(6, 1, 0, 14);
        brc(20, 1, 1, 4);
        brc(16, 0, 0, 7);
        rom[17] = mk(kLDS, 1'b0); dt[17] = 5;
        rom[18] = mk(kLDS, 1'b1); dt[18] = 2;
        brc(19, 1, 0, 11);
        rom[30] = mk(4'h3, 1'b1);
        rom[31] = mk(kLDS, 1'b0); dt[31] = 1;
        brc(32, 1, 1, 33);
      end
      2: begin
        rom[0] = mk(kLDS, 1'b1);
        rom[1] = mk(kHLT, 1'b0);
      end
      3: begin
        brc(2, 0, 1, 9);
        rom[3] = mk(kHLT, 1'b0);
      end
      default: ht[0] = 1;
    endcase
  endtask

  int cur = 0;

  task automatic at(input int n);
    repeat (n - cur) @(negedge clk);
    cur = n;
  endtask

  task automatic restart(input int p);
    #1 start = 1'b1;
    load_prog(p);
    @(posedge clk);
    #1 start = 1'b0;
    cur = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start = 1'b1; spur_en = 0;
    load_prog(1);
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("rst.pc", pc_a, 0);
    chk("rst.halt", halt_a, 0);
    chk("rst.cycle_ct", cyc_a, 0);
    chk("rst.mem_req", mem_req_a, 0);

    // Program 1: branches, ALU op, slow load, store, wrap-around.
    spur_en = 1;
    restart(1);
    at(4);  chk("alu.rf_we_c2", rf_we_a, 0);
    at(5);  chk("alu.rf_we_c3", rf_we_a, 1); chk("alu.wb_sel", wb_sel_a, 0);
    at(6);  chk("alu.pc", pc_a, 6); chk("alu.instr_ct", ins_a, 2);
    at(10); chk("brc.back_pc", pc_a, 16);
    at(12); chk("brc.not_taken_pc", pc_a, 17);
    at(13); chk("ld.req_exec", mem_req_a, 0);
    at(14); chk("ld.req_first", mem_req_a, 1);
    at(17); chk("b.to_req_last", mem_req_b, 1);
    at(18); chk("ld.req_fifth", mem_req_a, 1);
            chk("b.to_req_drop", mem_req_b, 0); chk("b.to_err", mem_err_b, 1);
            chk("b.to_pc", pc_b, 18); chk("b.to_rf_we", rf_we_b, 0);
    at(19); chk("ld.req_done", mem_req_a, 0);
            chk("ld.rf_we", rf_we_a, 1); chk("ld.wb_sel", wb_sel_a, 1);
    at(20); chk("ld.pc", pc_a, 18); chk("ld.instr_ct", ins_a, 6);
    at(35); chk("wrap.back_pc", pc_a, 1023);
    at(38); chk("wrap.fwd_pc", pc_a, 0); chk("wrap.instr_ct", ins_a, 12);
            chk("wrap.cycle_ct", cyc_a, 37);
    at(80); chk("b.cycle_sat", cyc_b, 63);

    // Reset in the middle of a load request.
    restart(1);
    at(15);
    #2 start = 1'b1;
    #1 chk("rstmem.mem_req", mem_req_a, 0); chk("rstmem.pc", pc_a, 0);
       chk("rstmem.instr_ct", ins_a, 0); chk("rstmem.cycle_ct", cyc_a, 0);
       chk("rstmem.halt", halt_a, 0);

    // Program 2: store that never acks.
    spur_en = 0;
    restart(2);
    at(6);  chk("st.b_req_last", mem_req_b, 1);
    at(7);  chk("st.b_req_drop", mem_req_b, 0); chk("st.b_err", mem_err_b, 1);
            chk("st.b_pc", pc_b, 1); chk("st.b_instr_ct", ins_b, 1);
            chk("st.b_rf_we", rf_we_b, 0); chk("st.a_still_req", mem_req_a, 1);
    at(9);  chk("st.b_halt", halt_b, 1); chk("st.b_halt_pc", pc_b, 1);
    at(15); chk("st.b_cycle_frozen", cyc_b, 8);

    // Program 3: halt after three retires, with idle acks.
    spur_en = 1;
    restart(3);
    at(10); chk("hlt.pre", halt_a, 0);
    at(11); chk("hlt.halt", halt_a, 1); chk("hlt.pc", pc_a, 3);
            chk("hlt.instr_ct", ins_a, 3); chk("hlt.cycle_ct", cyc_a, 10);
    at(25); chk("hlt.cycle_frozen", cyc_a, 10); chk("hlt.sticky", halt_a, 1);
            chk("hlt.pc_hold", pc_a, 3);

    // Program 4: ALU halt request on the first instruction.
    restart(4);
    at(3);  chk("ahlt.halt", halt_a, 1); chk("ahlt.pc", pc_a, 0);
            chk("ahlt.instr_ct", ins_a, 0); chk("ahlt.cycle_ct", cyc_a, 2);
    at(6);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
